inscache: RTL
=============

// Module: inscache
// PURPOSE
// - Direct-mapped instruction cache directly upstream of instruction fetch: serves the 32-bit instruction word at fetch PC.
// - Supports RV32C: instructions are 2-byte aligned, and a 32-bit instruction may straddle two cache lines.
// - On a miss, refills one line at a time from the memory controller through a word-read handshake. Read-only; no write path.
// PARAMETERS
// - LINE_OFF_W  4   log2(line bytes); 16-byte lines = 4 words
// - INDEX_W     5   log2(line count); 32 lines = 512 B
// PORTS
// - clk_in        in   1   clock, single domain
// - rst_in        in   1   asynchronous, active-low reset
// - rdy_in        in   1   global ready; when 0, all state is frozen
// - fetch_pc      in   32  fetch PC, bit0 always 0
// - ask_for       in   1   fetch wants the instruction at fetch_pc
// - give_you      out  1   g_ins is valid for fetch_pc this cycle
// - g_ins         out  32  instruction; bits [31:16] are 0 when the instruction is compressed
// - mc_req        out  1   word-read request to the memory controller, held until mc_done
// - mc_addr       out  32  word-aligned read address
// - mc_done       in   1   1-cycle pulse; mc_data is valid
// - mc_data       in   32  little-endian word
// BEHAVIOUR
// - Reset (rst_in=0, asynchronous): all valid bits=0, FSM=IDLE, mc_req=0, mc_addr=0, fill counter=0. give_you=0 while every valid bit is 0.
// - Address split: off=pc[LINE_OFF_W-1:0], idx=pc[LINE_OFF_W+INDEX_W-1:LINE_OFF_W], tag=the remaining upper bits.
// - Lookup is combinational, zero latency (fetch samples give_you/g_ins in the same cycle it drives fetch_pc).
//   - lo = halfword at pc; hi = halfword at pc+2.
//   - hi may belong to the next line when off==LINE_BYTES-2.
//   - Compressed means lo[1:0]!=2'b11; otherwise the instruction is 32-bit.
//   - give_you = ask_for & FSM==IDLE & hit(lo) & (compressed | hit(hi)).
//   - g_ins = compressed ? {16'b0,lo} : {hi,lo}.
// - FSM states:
//   - IDLE: if ask_for is set and a needed half misses, set miss_addr = line base of the first missing half (lo before hi), then go to FILL.
//   - FILL: word k=0..LINE_WORDS-1. Drive mc_req=1 and mc_addr=miss_addr+4k. On mc_done, write mc_data into the staging entry and advance k.
//     - After the last word, write tag and data and set valid (one cycle), then go to IDLE.
//     - A straddling miss on both halves takes two back-to-back fills.
// - mc_req drops in the cycle after the final mc_done. The memory controller may take any number of cycles per word.
// - During FILL, give_you=0 regardless of fetch_pc.
// - fetch_pc may change mid-fill (rob clear/redirect). The fill always runs to completion, because the memory controller cannot abort. The line is installed, and lookup then uses the new PC.
// - A refill overwrites the indexed line unconditionally: direct-mapped, no dirty state.
// - The straddle case with the same index on both lines (INDEX_W wrap) is legal: the hi fill evicts the lo line. The lo half then re-misses, which makes a livelock risk. Resolve it by latching lo into a 16-bit hold register when starting the hi fill. A hold-register hit counts as hit(lo) while pc is unchanged. The hold register is invalidated when pc changes.
// - Address wrap: pc=0xFFFFFFFE with a 32-bit instruction takes hi from line 0; the address computation wraps modulo 2^32.
// - rdy_in=0 freezes the FSM, counter and arrays. mc_req holds its value.
// STRUCTURE
// - Shared package: LINE_OFF_W/INDEX_W defaults, FSM state encoding (IDLE/FILL/INSTALL), and the `OPC_C_MASK compressed test reused by fetch.
// - Sub-module inscache_array: tag/valid/data storage with two combinational read ports (lo line, hi line) and one line-write port.
// - FSM, fill counter, staging buffer and hold register live in the top module.
// TESTING
// - Cold miss: ask pc=0x0. The bench sees mc_addr 0x0,0x4,0x8,0xC, each answered after 2 cycles. Then give_you=1 with g_ins equal to the word at 0x0. The following pc=0x4 hits with 0 latency.
// - Compressed: mem[0x10]=0x00014505 at pc=0x10. Expect give_you=1 and g_ins=0x00004505. Then pc=0x12 gives g_ins=0x00000001 with no new fill.
// - Straddle: pc=0x1E with a 32-bit instruction, both lines cold. Expect a fill of 0x10 then a fill of 0x20, then g_ins={mem16[0x20],mem16[0x1E]}.
// - Conflict: hit pc=0x0, then pc=0x200 (same index). After the refill, pc=0x0 misses again and refills.
// - Redirect mid-fill: change fetch_pc to 0x40 after the 2nd mc_done. The fill of 0x0 completes (4 words), then the fill of 0x40 starts. give_you stays 0 throughout.
// - Reset mid-fill: assert rst_in low between mc_done pulses. mc_req=0 immediately and all lines are invalid. After release, pc=0x0 misses again.

Source files
------------

// File: rtl/inscache_pkg.sv
// Shared definitions for the instruction cache and the fetch stage.

`ifndef INSCACHE_OPC_C_MASK_DEFINED
`define INSCACHE_OPC_C_MASK_DEFINED
`define OPC_C_MASK 2'b11
`endif

package inscache_pkg;

  localparam int unsigned DEF_LINE_OFF_W = 4;
  localparam int unsigned DEF_INDEX_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_INSTALL = 2'd2
  } state_t;

  // A halfword starts a compressed instruction unless both low bits are set.
  function automatic logic is_compressed(input logic [15:0] half);
    return (half[1:0] & `OPC_C_MASK) != `OPC_C_MASK;
  endfunction

endpackage

// File: rtl/inscache_array.sv
// Tag/valid/data storage: two combinational lookup ports, one line-write port.

module inscache_array #(
  parameter int unsigned INDEX_W   = 5,
  parameter int unsigned TAG_W     = 23,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 i_we,
  input  logic [INDEX_W-1:0]   i_widx,
  input  logic [TAG_W-1:0]     i_wtag,
  input  logic [LINE_BITS-1:0] i_wdata,
  input  logic [INDEX_W-1:0]   i_a_idx,
  input  logic [TAG_W-1:0]     i_a_tag,
  output logic                 o_a_hit,
  output logic [LINE_BITS-1:0] o_a_line,
  input  logic [INDEX_W-1:0]   i_b_idx,
  input  logic [TAG_W-1:0]     i_b_tag,
  output logic                 o_b_hit,
  output logic [LINE_BITS-1:0] o_b_line
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]     r_vld;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  // Valid bits are the only state that must be cleared by reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vld <= '0;
    end else if (i_we) begin
      r_vld[i_widx] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_a_hit  = r_vld[i_a_idx] & (r_tag[i_a_idx] == i_a_tag);
  assign o_a_line = r_data[i_a_idx];
  assign o_b_hit  = r_vld[i_b_idx] & (r_tag[i_b_idx] == i_b_tag);
  assign o_b_line = r_data[i_b_idx];

endmodule

// File: rtl/inscache.sv
// Direct-mapped RV32C instruction cache with zero-latency lookup and
// line-at-a-time refill over a word-read handshake.

module inscache
  import inscache_pkg::*;
#(
  parameter int unsigned LINE_OFF_W = DEF_LINE_OFF_W,
  parameter int unsigned INDEX_W    = DEF_INDEX_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] fetch_pc,
  input  logic        ask_for,
  output logic        give_you,
  output logic [31:0] g_ins,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  localparam int unsigned LINE_BYTES = 1 << LINE_OFF_W;
  localparam int unsigned LINE_WORDS = LINE_BYTES / 4;
  localparam int unsigned LINE_BITS  = LINE_BYTES * 8;
  localparam int unsigned TAG_W      = 32 - LINE_OFF_W - INDEX_W;
  localparam int unsigned CNT_W      = LINE_OFF_W - 2;
  localparam int unsigned LNUM_W     = 32 - LINE_OFF_W;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_mc_req;
  logic [31:0]           r_mc_addr;
  logic [LNUM_W-1:0]     r_miss_line;
  logic [31:0]           r_stage [LINE_WORDS];
  logic [LINE_BITS-1:0]  w_stage_line;
  logic                  r_hold_vld;
  logic [31:0]           r_hold_pc;
  logic [15:0]           r_hold;

  logic [30:0]           w_hpc_hi;
  logic                  w_hit_lo_arr;
  logic                  w_hit_hi;
  logic [LINE_BITS-1:0]  w_line_lo;
  logic [LINE_BITS-1:0]  w_line_hi;
  logic [15:0]           w_half_lo_arr;
  logic [15:0]           w_hi;
  logic [15:0]           w_lo;
  logic                  w_hold_hit;
  logic                  w_hit_lo;
  logic                  w_comp;

  logic                  w_start;
  logic [LNUM_W-1:0]     w_miss_line;
  logic                  w_latch_hold;
  logic                  w_word_done;
  logic                  w_last;
  logic                  w_install;

  // Halfword address of pc+2; wraps modulo 2^32 at the top of memory.
  assign w_hpc_hi = fetch_pc[31:1] + 31'd1;

  inscache_array #(
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_we     (w_install & rdy_in),
    .i_widx   (r_miss_line[INDEX_W-1:0]),
    .i_wtag   (r_miss_line[LNUM_W-1 -: TAG_W]),
    .i_wdata  (w_stage_line),
    .i_a_idx  (fetch_pc[LINE_OFF_W +: INDEX_W]),
    .i_a_tag  (fetch_pc[31 -: TAG_W]),
    .o_a_hit  (w_hit_lo_arr),
    .o_a_line (w_line_lo),
    .i_b_idx  (w_hpc_hi[LINE_OFF_W-1 +: INDEX_W]),
    .i_b_tag  (w_hpc_hi[30 -: TAG_W]),
    .o_b_hit  (w_hit_hi),
    .o_b_line (w_line_hi)
  );

  assign w_half_lo_arr = w_line_lo[{fetch_pc[LINE_OFF_W-1:1], 4'b0000} +: 16];
  assign w_hi          = w_line_hi[{w_hpc_hi[LINE_OFF_W-2:0], 4'b0000} +: 16];

  // The hold register stands in for the lo half only while pc is unchanged.
  assign w_hold_hit = r_hold_vld & (r_hold_pc == fetch_pc);
  assign w_hit_lo   = w_hit_lo_arr | w_hold_hit;
  assign w_lo       = w_hit_lo_arr ? w_half_lo_arr : r_hold;
  assign w_comp     = is_compressed(w_lo);

  assign give_you = ask_for & (r_state == ST_IDLE) & w_hit_lo & (w_comp | w_hit_hi);
  assign g_ins    = w_comp ? {16'h0000, w_lo} : {w_hi, w_lo};
  assign mc_req   = r_mc_req;
  assign mc_addr  = r_mc_addr;

  // Flatten the staging words into one line, word 0 in the low bits.
  always_comb begin
    w_stage_line = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      w_stage_line[k*32 +: 32] = r_stage[k];
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and fill control; lo is always refilled before hi.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_miss_line  = '0;
    w_latch_hold = 1'b0;
    w_word_done  = 1'b0;
    w_last       = 1'b0;
    w_install    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ask_for && !w_hit_lo) begin
          w_start     = 1'b1;
          w_miss_line = fetch_pc[31:LINE_OFF_W];
          w_state_nxt = ST_FILL;
        end else if (ask_for && !w_comp && !w_hit_hi) begin
          w_start      = 1'b1;
          w_miss_line  = w_hpc_hi[30:LINE_OFF_W-1];
          w_latch_hold = 1'b1;
          w_state_nxt  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mc_done) begin
          w_word_done = 1'b1;
          if (r_cnt == CNT_W'(LINE_WORDS - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = ST_INSTALL;
          end
        end
      end
      ST_INSTALL: begin
        w_install   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fill counter, request/address registers and lo-half hold register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt       <= '0;
      r_mc_req    <= 1'b0;
      r_mc_addr   <= '0;
      r_miss_line <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_pc   <= '0;
      r_hold      <= '0;
    end else if (rdy_in) begin
      if (w_start) begin
        r_miss_line <= w_miss_line;
        r_mc_addr   <= {w_miss_line, LINE_OFF_W'(0)};
        r_mc_req    <= 1'b1;
        r_cnt       <= '0;
      end
      if (w_word_done) begin
        if (w_last) begin
          r_mc_req <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_cnt     <= r_cnt + CNT_W'(1);
          r_mc_addr <= r_mc_addr + 32'd4;
        end
      end
      if (w_latch_hold) begin
        r_hold_vld <= 1'b1;
        r_hold_pc  <= fetch_pc;
        r_hold     <= w_lo;
      end else if (r_hold_vld && (fetch_pc != r_hold_pc)) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  // Staging buffer collects returned words until the line is installed.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_word_done) begin
      r_stage[r_cnt] <= mc_data;
    end
  end

endmodule
